// File: rtl/fetch_prefetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited memory reads, and buffers {pc, instr} pairs for the core.
// Optional macro FETCH_PREFETCH_PERF_EN adds saturating starve and flush-drop counters.
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_srst,
  output logic        o_memReqValid,
  input  logic        i_memReqReady,
  output logic [31:0] o_memReqAddr,
  input  logic        i_memRspValid,
  input  logic [31:0] i_memRspData,
  input  logic        i_redirectValid,
  input  logic [31:0] i_redirectPc,
  output logic        o_instrValid,
  input  logic        i_instrReady,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc
`ifdef FETCH_PREFETCH_PERF_EN
  ,
  output logic [31:0] o_starveCount,
  output logic [31:0] o_flushDropCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  cnt_t          count, outstanding, discard;
  logic [31:0]   fetch_pc, rsp_pc;
  logic          run;
  logic [CW:0]   credit_used;
  logic          req_fire, rsp_ok, rsp_drop, push, pop;
  logic [31:0]   redirect_pc;

  // NOTE: every output of an always_comb block is assigned first, so no path can infer a latch.
  always_comb begin
    credit_used   = {1'b0, count} + {1'b0, outstanding};
    // run holds requests off for the first cycle after reset is released.
    o_memReqValid = !i_srst && !i_redirectValid && run && (credit_used < (CW+1)'(DEPTH));
    o_memReqAddr  = fetch_pc;
    req_fire      = o_memReqValid && i_memReqReady;
    rsp_ok        = i_memRspValid && (outstanding != '0);
    rsp_drop      = rsp_ok && (i_redirectValid || (discard != '0));
    push          = rsp_ok && !rsp_drop;
    o_instrValid  = !i_srst && (count != '0);
    pop           = o_instrValid && i_instrReady && !i_redirectValid;
    o_instruction = o_instrValid ? instr_mem[rd_ptr] : '0;
    o_pc          = o_instrValid ? pc_mem[rd_ptr]    : '0;
    redirect_pc   = i_redirectPc & 32'hFFFF_FFFC;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      fetch_pc    <= RESET_PC & 32'hFFFF_FFFC;
      rsp_pc      <= RESET_PC & 32'hFFFF_FFFC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;
      if (i_redirectValid) begin
        fetch_pc    <= redirect_pc;
        rsp_pc      <= redirect_pc;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        outstanding <= outstanding - cnt_t'(rsp_ok);
        // Every request still in flight is now stale, whether or not it already was.
        discard     <= outstanding - cnt_t'(rsp_ok);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_ok);
        discard     <= discard - cnt_t'(rsp_drop);
        count       <= count + cnt_t'(push) - cnt_t'(pop);
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only read while count says they are valid.
  always_ff @(posedge i_clk) begin
    if (push && !i_srst) begin
      instr_mem[wr_ptr] <= i_memRspData;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

`ifdef FETCH_PREFETCH_PERF_EN
  logic starve;
  assign starve = !o_instrValid && i_instrReady && !i_redirectValid;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      o_starveCount    <= '0;
      o_flushDropCount <= '0;
    end else begin
      if (starve   && (o_starveCount    != '1)) o_starveCount    <= o_starveCount + 32'd1;
      if (rsp_drop && (o_flushDropCount != '1)) o_flushDropCount <= o_flushDropCount + 32'd1;
    end
  end
`endif

  // A response with nothing outstanding is a memory protocol violation; it is ignored.
  a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (i_srst)
    !(i_memRspValid && (outstanding == '0)));

endmodule
